// File: rtl/uart_pkg.sv
// Shared UART definitions: TX frame state encoding and parity-type constants.
package uart_pkg;

  // TX frame controller state encoding (3-bit).
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = TX_IDLE,
    ST_START  = TX_START,
    ST_DATA   = TX_DATA,
    ST_PARITY = TX_PARITY,
    ST_STOP   = TX_STOP
  } tx_state_t;

  // Parity type selector values for PAR_TYP.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity generator: captures the parity bit of a byte when the load strobe fires,
// so the value stays stable for the whole frame regardless of later input changes.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] data,
  input  logic              par_typ,
  input  logic              load,
  output logic              par_bit
);

  // Register the parity of the accepted byte; odd parity inverts the XOR-reduction.
  // NOTE: sequential state is always written with non-blocking assignments so that
  // every register samples its inputs as they were before the clock edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_bit <= 1'b0;
    end else if (load) begin
      par_bit <= (^data) ^ (par_typ == PAR_ODD);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: accepts a byte, loads and sequences the external
// serializer, and drives the line with start, MSB-first data, optional parity, stop.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VLD,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              SER_DATA,
  input  logic              SER_DONE,
  output logic              SER_EN,
  output logic              SER_LOAD,
  output logic              TX_OUT,
  output logic              BUSY
);

  tx_state_t state;
  logic      par_en_q;
  logic      par_bit;
  logic      accept;

  // A new byte is taken only between frames or in the stop bit (back-to-back).
  assign accept = DATA_VLD && (state == ST_IDLE || state == ST_STOP);

  // The parity register already folds in PAR_TYP at accept time, so the parity
  // type needs no separate latch here.
  uart_parity_calc #(
    .DATA_W (DATA_W)
  ) u_parity (
    .CLK     (CLK),
    .RST     (RST),
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .load    (accept),
    .par_bit (par_bit)
  );

  // Frame sequencer: state register plus the parity-enable captured at accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      par_en_q <= 1'b0;
    end else begin
      if (accept) begin
        par_en_q <= PAR_EN;
      end
      case (state)
        ST_IDLE:   if (accept) state <= ST_START;
        ST_START:  state <= ST_DATA;
        ST_DATA:   if (SER_DONE) state <= par_en_q ? ST_PARITY : ST_STOP;
        ST_PARITY: state <= ST_STOP;
        ST_STOP:   state <= accept ? ST_START : ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Combinational outputs decoded from state; the serial data bit passes straight through.
  // NOTE: every output gets a default at the top of always_comb, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    TX_OUT = 1'b1;
    SER_EN = 1'b0;
    BUSY   = (state != ST_IDLE);
    // The reset term keeps the load strobe quiet while RST is held, even though
    // the state already reads IDLE and DATA_VLD might be high.
    SER_LOAD = accept && RST;
    case (state)
      ST_IDLE:   TX_OUT = 1'b1;
      ST_START: begin
        TX_OUT = 1'b0;
        SER_EN = 1'b1;
      end
      ST_DATA: begin
        TX_OUT = SER_DATA;
        SER_EN = !SER_DONE;
      end
      ST_PARITY: TX_OUT = par_bit;
      ST_STOP:   TX_OUT = 1'b1;
      default:   TX_OUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a behavioural serializer closes the loop,
// and expected line waveforms are built from the byte, parity settings and frame rules.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int DATA_W = 8;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [DATA_W-1:0] P_DATA = '0;
  logic              DATA_VLD = 1'b0;
  logic              PAR_EN = 1'b0;
  logic              PAR_TYP = 1'b0;
  logic              SER_DATA;
  logic              SER_DONE;
  logic              SER_EN;
  logic              SER_LOAD;
  logic              TX_OUT;
  logic              BUSY;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_ctrl #(.DATA_W(DATA_W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .P_DATA   (P_DATA),
    .DATA_VLD (DATA_VLD),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .SER_DATA (SER_DATA),
    .SER_DONE (SER_DONE),
    .SER_EN   (SER_EN),
    .SER_LOAD (SER_LOAD),
    .TX_OUT   (TX_OUT),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  // Behavioural serializer: loads on SER_LOAD, presents the next MSB one cycle
  // after each SER_EN, and raises SER_DONE once DATA_W bits have been shifted.
  logic [DATA_W-1:0] sh;
  int                sh_cnt;
  logic              sh_out;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh     <= '0;
      sh_cnt <= 0;
      sh_out <= 1'b0;
    end else if (SER_LOAD) begin
      sh     <= P_DATA;
      sh_cnt <= 0;
    end else if (SER_EN) begin
      sh_out <= sh[DATA_W-1];
      sh     <= sh << 1;
      sh_cnt <= sh_cnt + 1;
    end
  end

  assign SER_DATA = sh_out;
  assign SER_DONE = (sh_cnt == DATA_W);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Even parity makes the total count of ones even; odd parity makes it odd.
  function automatic logic ref_parity(input logic [DATA_W-1:0] d, input logic typ);
    int ones;
    ones = $countones(d);
    return ((ones % 2) == 1) ? ~typ : typ;
  endfunction

  // Present a byte while the controller is idle or in its stop bit; the frame
  // starts on the following edge. Afterwards the inputs are scrambled.
  task automatic send(input logic [DATA_W-1:0] d, input logic en, input logic typ);
    P_DATA   = d;
    PAR_EN   = en;
    PAR_TYP  = typ;
    DATA_VLD = 1'b1;
    #1;
    check("ser_load_on_accept", SER_LOAD, 1'b1);
    @(posedge CLK);
    #1;
    DATA_VLD = 1'b0;
    P_DATA   = DATA_W'($urandom);
    PAR_TYP  = 1'($urandom);
    PAR_EN   = 1'($urandom);
  endtask

  // Walk one frame cycle by cycle against the expected line waveform.
  // chain: return during the stop bit so the caller can send the next byte.
  // noise: drive a 0x00 request during the mid-frame cycles, which must be ignored.
  task automatic watch(input logic [DATA_W-1:0] d, input logic en, input logic typ,
                       input bit chain, input bit noise);
    logic exp_q[$];
    int   len;
    exp_q.push_back(1'b0);
    for (int b = DATA_W - 1; b >= 0; b--) exp_q.push_back(d[b]);
    if (en) exp_q.push_back(ref_parity(d, typ));
    exp_q.push_back(1'b1);
    len = exp_q.size();
    for (int i = 0; i < len; i++) begin
      DATA_VLD = noise && (i >= 1) && (i <= len - 2);
      if (noise) P_DATA = '0;
      PAR_EN  = 1'($urandom);
      PAR_TYP = 1'($urandom);
      #1;
      check($sformatf("tx_bit%0d", i), TX_OUT, exp_q[i]);
      check($sformatf("busy_bit%0d", i), BUSY, 1'b1);
      check($sformatf("ser_en_bit%0d", i), SER_EN, (i < DATA_W) ? 1'b1 : 1'b0);
      if (DATA_VLD) check("ser_load_ignored", SER_LOAD, 1'b0);
      if (i == len - 1) begin
        DATA_VLD = 1'b0;
        if (chain) return;
      end
      @(posedge CLK);
      #1;
    end
    #1;
    check("idle_tx", TX_OUT, 1'b1);
    check("idle_busy", BUSY, 1'b0);
    check("idle_ser_en", SER_EN, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic              en;
    logic              typ;
    bit                chain;
    bit                noise;

    // Reset held for three cycles with a pending request that must not load.
    DATA_VLD = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_tx", TX_OUT, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_ser_en", SER_EN, 1'b0);
    check("rst_ser_load", SER_LOAD, 1'b0);
    DATA_VLD = 1'b0;
    RST = 1'b1;
    step();
    check("post_rst_tx", TX_OUT, 1'b1);
    check("post_rst_busy", BUSY, 1'b0);
    check("post_rst_ser_en", SER_EN, 1'b0);

    // Directed frames.
    send(8'hA5, 1'b0, PAR_EVEN); watch(8'hA5, 1'b0, PAR_EVEN, 0, 0);
    send(8'hA5, 1'b1, PAR_EVEN); watch(8'hA5, 1'b1, PAR_EVEN, 0, 0);
    send(8'hA5, 1'b1, PAR_ODD);  watch(8'hA5, 1'b1, PAR_ODD, 0, 0);
    send(8'h01, 1'b1, PAR_EVEN); watch(8'h01, 1'b1, PAR_EVEN, 0, 0);

    // Back-to-back frames with no idle gap.
    send(8'h3C, 1'b0, PAR_EVEN); watch(8'h3C, 1'b0, PAR_EVEN, 1, 0);
    send(8'hFF, 1'b1, PAR_ODD);  watch(8'hFF, 1'b1, PAR_ODD, 0, 0);

    // Mid-frame requests are ignored.
    send(8'h81, 1'b1, PAR_EVEN); watch(8'h81, 1'b1, PAR_EVEN, 0, 1);

    // Randomized frames, randomly chained and with random mid-frame noise.
    for (int k = 0; k < 30; k++) begin
      d     = DATA_W'($urandom);
      en    = 1'($urandom);
      typ   = 1'($urandom);
      chain = (k < 29) && ($urandom_range(0, 1) == 1);
      noise = ($urandom_range(0, 1) == 1);
      send(d, en, typ);
      watch(d, en, typ, chain, noise);
    end

    // Asynchronous reset in the middle of the data bits, no clock edge needed.
    send(8'h5A, 1'b1, PAR_ODD);
    step(); step(); step();
    #1;
    check("mid_busy_before_rst", BUSY, 1'b1);
    RST = 1'b0;
    #1;
    check("mid_rst_tx", TX_OUT, 1'b1);
    check("mid_rst_busy", BUSY, 1'b0);
    check("mid_rst_ser_en", SER_EN, 1'b0);
    step(); step();
    RST = 1'b1;
    step();
    check("after_mid_rst_busy", BUSY, 1'b0);
    send(8'hC3, 1'b1, PAR_EVEN); watch(8'hC3, 1'b1, PAR_EVEN, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame controller for the UART transmit path, sitting directly around the TX serializer.
- Accepts a parallel byte handshake, loads the serializer and sequences it, and computes parity.
- Drives the single-bit TX line: start bit, DATA_W data bits MSB-first from the serializer, optional parity bit, stop bit.
- CLK runs at bit rate: one CLK cycle equals one bit period.

Parameters:
DATA_W, 8, data bits per frame; must match the serializer's DATA_W.

Ports:
CLK  input  1  bit-rate clock.
RST  input  1  asynchronous, active-low reset.
P_DATA  input  DATA_W  parallel byte to send; valid while DATA_VLD is high.
DATA_VLD  input  1  single-cycle request; accepted only when the block is in IDLE or STOP.
PAR_EN  input  1  1 = insert parity bit; sampled at accept.
PAR_TYP  input  1  0 = even, 1 = odd; sampled at accept.
SER_DATA  input  1  current serial bit from the serializer.
SER_DONE  input  1  serializer has shifted out all DATA_W bits.
SER_EN  output  1  serializer shift enable.
SER_LOAD  output  1  serializer load strobe; gated copy of DATA_VLD.
TX_OUT  output  1  UART line, idle high.
BUSY  output  1  high while a frame is in progress.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state = IDLE, TX_OUT = 1, BUSY = 0, SER_EN = 0, SER_LOAD = 0.
  - Parity register = 0; latched PAR_EN and PAR_TYP = 0.
- States: IDLE, START, DATA, PARITY, STOP. State is registered; outputs are combinational from state and inputs.
- Accept:
  - Condition: DATA_VLD = 1 while state is IDLE or STOP.
  - On the accept edge: go to START; latch PAR_EN, PAR_TYP, and par_bit = ^P_DATA XOR PAR_TYP.
  - DATA_VLD in any other state is ignored.
- SER_LOAD = DATA_VLD AND (state == IDLE OR state == STOP). This guarantees the serializer is never reloaded mid-frame.
- SER_EN = (state == START) OR (state == DATA AND NOT SER_DONE).
- Serializer contract:
  - The serializer presents the next bit on SER_DATA one cycle after each SER_EN cycle.
  - SER_DONE rises once DATA_W bits have been shifted.
  - Net effect: DATA lasts exactly DATA_W cycles.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA unconditionally after 1 cycle.
  - DATA -> PARITY when SER_DONE and latched PAR_EN = 1.
  - DATA -> STOP when SER_DONE and latched PAR_EN = 0.
  - PARITY -> STOP after 1 cycle.
  - STOP -> START on accept (back-to-back frames, no idle gap); otherwise STOP -> IDLE.
- TX_OUT mux by state:
  - IDLE = 1
  - START = 0
  - DATA = SER_DATA
  - PARITY = par_bit
  - STOP = 1
- BUSY = (state != IDLE). BUSY stays high through STOP.
- Frame length from the START cycle through the STOP cycle: 1 + DATA_W + PAR_EN + 1 cycles (10 or 11 for DATA_W = 8).
- Latency: the first START cycle appears on TX_OUT in the cycle after the accept edge.
- Changes to PAR_EN, PAR_TYP or P_DATA after accept have no effect on the frame in flight.
- SER_DONE never asserting in DATA: the block stays in DATA. There is no timeout; this is the system integrator's responsibility.
- SER_DONE asserted in any state other than DATA: ignored.

Decomposition:
- Shared package uart_pkg holds:
  - TX state encoding localparams (IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4; 3-bit).
  - PAR_EVEN = 0 and PAR_ODD = 1 constants.
- One natural sub-module: uart_parity_calc.
  - Inputs: DATA_W data, par_typ, load strobe.
  - Output: registered par_bit with asynchronous active-low reset.
  - Instantiated once inside uart_tx_ctrl.
- The serializer itself is not instantiated here; the two blocks are wired together at the UART TX top level.

Test Plan:
- Reset: hold RST = 0 for 3 cycles, then release -> TX_OUT = 1, BUSY = 0, SER_EN = 0. Assert RST low mid-DATA -> TX_OUT = 1 and BUSY = 0 immediately, with no clock edge required.
- 0xA5, PAR_EN = 0: TX_OUT sequence = 0, 1,0,1,0,0,1,0,1, 1 (10 cycles), then IDLE. SER_EN high for exactly 8 cycles: START plus the first 7 DATA cycles.
- 0xA5, PAR_EN = 1, even: parity bit = 0, 11-cycle frame. Same byte with odd parity: parity bit = 1. Also 0x01 with even parity -> parity bit = 1.
- Back-to-back: 0x3C then 0xFF, with DATA_VLD for 0xFF pulsed in STOP of frame 1 -> frame 2's START immediately follows STOP with no idle cycle, and BUSY never drops.
- DATA_VLD = 1 with 0x00 during DATA and PARITY of a frame carrying 0x81 -> ignored. SER_LOAD stays 0, the frame completes as 0x81, and TX returns to IDLE.
- PAR_EN toggled mid-frame -> frame length follows the value latched at accept.
